// File: rtl/tdm_demux_8ch.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_8ch
// Brief    : Receive end of an NCH-slot TDM link. Steers serial bits into
//            channel slots and presents each complete frame as a parallel word.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux_8ch #(
    parameter int NCH   = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    input  logic             frame_sync,
    output logic [NCH-1:0]   dout,
    output logic             dout_vld,
    output logic [SEL_W-1:0] slot,
    output logic             locked,
    output logic             sync_err
);

    localparam logic [0:0]       c_hunt = 1'b0;
    localparam logic [0:0]       c_run  = 1'b1;
    localparam logic [SEL_W-1:0] c_zero = '0;
    localparam logic [SEL_W-1:0] c_one  = SEL_W'(1);
    localparam logic [SEL_W-1:0] c_last = SEL_W'(NCH - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [SEL_W-1:0] r_slot;
    // The last channel never lands here; it goes straight into dout.
    logic [NCH-2:0]   r_shadow;
    logic [NCH-1:0]   r_dout;
    logic             r_dout_vld;
    logic             r_sync_err;

    logic             w_load_ch0;
    logic             w_store;
    logic             w_done;
    logic             w_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_hunt;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_hunt:  if (din_vld && frame_sync) w_state_nxt = c_run;
            c_run:   w_state_nxt = c_run;
            default: w_state_nxt = c_hunt;
        endcase
    end

    always_comb begin
        w_load_ch0 = 1'b0;
        w_store    = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        if (din_vld) begin
            case (r_state)
                c_hunt: w_load_ch0 = frame_sync;
                c_run: begin
                    // A sync away from slot 0 restarts the frame at this bit.
                    if (frame_sync && (r_slot != c_zero)) begin
                        w_err      = 1'b1;
                        w_load_ch0 = 1'b1;
                    end else if (r_slot == c_last) begin
                        w_done = 1'b1;
                    end else begin
                        w_store = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot     <= c_zero;
            r_shadow   <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_dout_vld <= w_done;
            r_sync_err <= w_err;
            if (w_load_ch0) begin
                r_shadow[0] <= din;
                r_slot      <= c_one;
            end else if (w_store) begin
                r_shadow[r_slot] <= din;
                r_slot           <= r_slot + c_one;
            end else if (w_done) begin
                r_dout <= {din, r_shadow};
                r_slot <= c_zero;
            end
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign slot     = r_slot;
    assign locked   = (r_state == c_run);
    assign sync_err = r_sync_err;

endmodule
`default_nettype wire
